sdes_round_ctrl: RTL and testbench

- Iterative S-DES encrypt/decrypt engine that time-shares one instance of the team's existing Feistel round block (fk: 8-bit block in, 8-bit round key in, 8-bit block out) across both rounds.
- Sequences key schedule, IP, round 1, switch, round 2 and IP⁻¹ under a valid/ready handshake on input and output.
- Sits between the host interface and the Feistel datapath; one block in flight at a time.

---
 rtl/sdes_round_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sdes_round_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdes_round_ctrl.sv
// Iterative S-DES engine: one shared Feistel round (fk) used for both rounds,
// sequenced by a small FSM behind valid/ready handshakes on input and output.
module sdes_fk (
  input  logic [0:7] blk_i,
  input  logic [0:7] rk_i,
  output logic [0:7] blk_o
);
  localparam logic [1:0] S0 [16] = '{
    2'd1, 2'd0, 2'd3, 2'd2,
    2'd3, 2'd2, 2'd1, 2'd0,
    2'd0, 2'd2, 2'd1, 2'd3,
    2'd3, 2'd1, 2'd3, 2'd2
  };
  localparam logic [1:0] S1 [16] = '{
    2'd0, 2'd1, 2'd2, 2'd3,
    2'd2, 2'd0, 2'd1, 2'd3,
    2'd3, 2'd0, 2'd1, 2'd0,
    2'd2, 2'd1, 2'd0, 2'd3
  };

  logic [0:3] r;
  logic [0:7] ep;
  logic [0:7] x;
  logic [0:3] s;
  logic [0:3] p4;

  assign r  = blk_i[4:7];
  assign ep = {r[3], r[0], r[1], r[2],
               r[1], r[2], r[3], r[0]};
  assign x  = ep ^ rk_i;
  // S-box row from outer bits, column from inner bits
  assign s  = {S0[{x[0], x[3], x[1], x[2]}],
               S1[{x[4], x[7], x[5], x[6]}]};
  assign p4 = {s[1], s[3], s[2], s[0]};
  assign blk_o = {blk_i[0:3] ^ p4, r};
endmodule

module sdes_round_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [0:7] din,
  input  logic [0:9] key,
  input  logic       mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [0:7] dout,
  output logic       busy,
  output logic [0:7] k1,
  output logic [0:7] k2
);
  typedef enum logic [2:0] {
    IDLE, KEYGEN, R1, R2, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [0:7] din_q, din_d;
  logic [0:9] key_q, key_d;
  logic       mode_q, mode_d;
  logic [0:7] blk_q, blk_d;
  logic [0:7] k1_q, k1_d;
  logic [0:7] k2_q, k2_d;
  logic [0:7] dout_q, dout_d;

  logic [0:7] fk_in;
  logic [0:7] fk_key;
  logic [0:7] fk_out;

  function automatic logic [0:9] p10(input logic [0:9] k);
    return {k[2], k[4], k[1], k[6], k[3],
            k[9], k[0], k[8], k[7], k[5]};
  endfunction

  function automatic logic [0:7] p8(input logic [0:9] k);
    return {k[5], k[2], k[6], k[3],
            k[7], k[4], k[9], k[8]};
  endfunction

  function automatic logic [0:7] ip(input logic [0:7] b);
    return {b[1], b[5], b[2], b[0],
            b[3], b[7], b[4], b[6]};
  endfunction

  function automatic logic [0:7] ip_inv(input logic [0:7] b);
    return {b[3], b[0], b[2], b[4],
            b[6], b[1], b[7], b[5]};
  endfunction

  logic [0:9] pk;
  logic [0:9] ls1;
  logic [0:9] ls3;

  assign pk  = p10(key_q);
  // Halves rotated left by 1 for K1, by 3 in total for K2
  assign ls1 = {pk[1:4], pk[0], pk[6:9], pk[5]};
  assign ls3 = {pk[3:4], pk[0:2], pk[8:9], pk[5:7]};

  sdes_fk u_fk (
    .blk_i (fk_in),
    .rk_i  (fk_key),
    .blk_o (fk_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      din_q   <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      blk_q   <= '0;
      k1_q    <= '0;
      k2_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      key_q   <= key_d;
      mode_q  <= mode_d;
      blk_q   <= blk_d;
      k1_q    <= k1_d;
      k2_q    <= k2_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    key_d   = key_q;
    mode_d  = mode_q;
    blk_d   = blk_q;
    k1_d    = k1_q;
    k2_d    = k2_q;
    dout_d  = dout_q;
    fk_in   = '0;
    fk_key  = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          din_d   = din;
          key_d   = key;
          mode_d  = mode;
          state_d = KEYGEN;
        end
      end
      KEYGEN: begin
        k1_d    = p8(ls1);
        k2_d    = p8(ls3);
        blk_d   = ip(din_q);
        state_d = R1;
      end
      R1: begin
        fk_in   = blk_q;
        fk_key  = mode_q ? k2_q : k1_q;
        blk_d   = {fk_out[4:7], fk_out[0:3]};
        state_d = R2;
      end
      R2: begin
        fk_in   = blk_q;
        fk_key  = mode_q ? k1_q : k2_q;
        dout_d  = ip_inv(fk_out);
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign dout      = dout_q;
  assign k1        = k1_q;
  assign k2        = k2_q;
endmodule

// File: tb/tb_sdes_round_ctrl.sv
// Bench for sdes_round_ctrl: directed S-DES vectors plus random blocks
// checked against a table-driven S-DES model.
module tb_sdes_round_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [9:0] key;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;
  logic [7:0] k1;
  logic [7:0] k2;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdes_round_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .key       (key),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy),
    .k1        (k1),
    .k2        (k2)
  );

  int P10 [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  int P8  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  int IP  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  int IPI [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  int EP  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  int P4  [4]  = '{2, 4, 3, 1};
  int S0 [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0},
                    '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int S1 [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3},
                    '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic int tbl(int w, int i);
    case (w)
      0: return P10[i];
      1: return P8[i];
      2: return IP[i];
      3: return IPI[i];
      4: return EP[i];
      default: return P4[i];
    endcase
  endfunction

  // Position p (1-indexed) of an n-bit value is bit n-p
  function automatic int perm(int v, int nin, int nout, int w);
    int r = 0;
    for (int i = 0; i < nout; i++)
      if (((v >> (nin - tbl(w, i))) & 1) != 0)
        r |= 1 << (nout - 1 - i);
    return r;
  endfunction

  function automatic int rol5(int h, int s);
    return ((h << s) | (h >> (5 - s))) & 31;
  endfunction

  function automatic int fk(int b, int k);
    int l, r, x, a, c, s0, s1, p;
    l  = (b >> 4) & 15;
    r  = b & 15;
    x  = perm(r, 4, 8, 4) ^ k;
    a  = (x >> 4) & 15;
    c  = x & 15;
    s0 = S0[((a >> 3) & 1) * 2 + (a & 1)][(a >> 1) & 3];
    s1 = S1[((c >> 3) & 1) * 2 + (c & 1)][(c >> 1) & 3];
    p  = perm((s0 << 2) | s1, 4, 4, 5);
    return ((l ^ p) << 4) | r;
  endfunction

  task automatic model(input int d, input int k, input int m,
                       output logic [7:0] res,
                       output logic [7:0] ek1,
                       output logic [7:0] ek2);
    int t, hl, hr, b, ka, kb;
    t   = perm(k, 10, 10, 0);
    hl  = (t >> 5) & 31;
    hr  = t & 31;
    ka  = perm((rol5(hl, 1) << 5) | rol5(hr, 1), 10, 8, 1);
    kb  = perm((rol5(hl, 3) << 5) | rol5(hr, 3), 10, 8, 1);
    b   = perm(d, 8, 8, 2);
    b   = fk(b, (m != 0) ? kb : ka);
    b   = ((b & 15) << 4) | ((b >> 4) & 15);
    b   = fk(b, (m != 0) ? ka : kb);
    res = 8'(perm(b, 8, 8, 3));
    ek1 = 8'(ka);
    ek2 = 8'(kb);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic do_op(input logic [7:0] d, input logic [9:0] k,
                       input logic m, input int hold,
                       input logic pulse);
    logic [7:0] ed, ek1, ek2;
    int n, g;
    model(int'(d), int'(k), int'(m), ed, ek1, ek2);
    @(negedge clk);
    din = d; key = k; mode = m;
    in_valid = 1'b1; out_ready = 1'b0;
    g = 0;
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("accept", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      din = 8'($urandom); key = 10'($urandom);
      mode = 1'($urandom);
      in_valid = pulse && (n == 2);
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("k1", 32'(k1), 32'(ek1));
        chk("k2", 32'(k2), 32'(ek2));
      end
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'd3);
    chk("dout", 32'(dout), 32'(ed));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_dout", 32'(dout), 32'(ed));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ov_clr", 32'(out_valid), 32'd0);
    chk("idle_rdy", 32'(in_ready), 32'd1);
    chk("dout_keep", 32'(dout), 32'(ed));
  endtask

  initial begin
    logic [7:0] res [$];
    int acct [2];
    int acc, cnt;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    din = 8'h00; key = 10'h000; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_k1", 32'(k1), 32'd0);
    chk("rst_k2", 32'(k2), 32'd0);

    // Known-answer vectors, fixed constants independent of the model
    do_op(8'b10010111, 10'b1010000010, 1'b0, 5, 1'b0);
    chk("kat_enc", 32'(dout), 32'h38);
    chk("kat_k1", 32'(k1), 32'hA4);
    chk("kat_k2", 32'(k2), 32'h43);
    do_op(8'b00111000, 10'b1010000010, 1'b1, 2, 1'b0);
    chk("kat_dec", 32'(dout), 32'h97);
    chk("kat_k1_dec", 32'(k1), 32'hA4);

    // Back-to-back with out_ready high and in_valid held
    acc = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) res.push_back(dout);
      if (in_ready && acc < 2) begin
        din  = (acc == 0) ? 8'h97 : 8'h38;
        mode = (acc != 0);
        key  = 10'h282;
        in_valid = 1'b1;
        acct[acc] = c;
        acc++;
      end else begin
        if (acc == 2) in_valid = 1'b0;
        if (!in_ready) begin
          din = 8'($urandom); key = 10'($urandom);
          mode = 1'($urandom);
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("b2b_acc", 32'(acc), 32'd2);
    chk("b2b_gap", 32'(acct[1] - acct[0]), 32'd5);
    chk("b2b_cnt", 32'(res.size()), 32'd2);
    if (res.size() == 2) begin
      chk("b2b_r0", 32'(res[0]), 32'h38);
      chk("b2b_r1", 32'(res[1]), 32'h97);
    end

    // Reset while in R1 abandons the block
    @(negedge clk);
    din = 8'h97; key = 10'h282; mode = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rdy", 32'(in_ready), 32'd1);
    chk("mid_dout", 32'(dout), 32'd0);
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("mid_no_ov", 32'(cnt), 32'd0);
    do_op(8'h97, 10'h282, 1'b0, 0, 1'b0);
    chk("post_rst_enc", 32'(dout), 32'h38);

    // Request pulsed during R2 is ignored
    do_op(8'h5A, 10'h3C1, 1'b0, 1, 1'b1);
    cnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
    end
    chk("ign_no_ov", 32'(cnt), 32'd0);
    chk("ign_rdy", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++)
      do_op(8'($urandom), 10'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
